// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller: FSM state encoding and
// the ALU unit-group codes carried in ALU_FUN[3:2] (shared with the decoder).
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } ctrl_state_t;

  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  localparam int TMR_W = 8;

endpackage

// File: rtl/alu_cmd_timer.sv
// WAIT-state cycle counter; o_expired flags the TIMEOUT-th WAIT cycle.
// Only instantiated when ALU_CMD_TIMEOUT_EN is defined.
module alu_cmd_timer
  import alu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_inc)  r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt counts completed empty WAIT cycles, so TIMEOUT-1 marks the last allowed one
  assign o_expired = (r_cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: accepts one command, pulses ALU_EN, returns the result.
// Optional WAIT timeout with error response enabled by ALU_CMD_TIMEOUT_EN.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_fun,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  output logic [3:0]          ALU_FUN,
  output logic                ALU_EN,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                alu_out_valid,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  ctrl_state_t         r_state;
  logic [DATA_W-1:0]   r_a, r_b;
  logic [3:0]          r_fun;
  logic                r_alu_en;
  logic                r_rsp_valid;
  logic [2*DATA_W-1:0] r_rsp_data;
  logic                w_expired;

`ifdef ALU_CMD_TIMEOUT_EN
  logic r_rsp_err;

  alu_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (CLK),
    .rst_n     (RST),
    .i_clr     (r_state == ISSUE),
    .i_inc     ((r_state == WAIT) && !alu_out_valid),
    .o_expired (w_expired)
  );

  assign rsp_err = r_rsp_err;
`else
  assign w_expired = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_fun       <= '0;
      r_alu_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef ALU_CMD_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_alu_en <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_a      <= cmd_a;
          r_b      <= cmd_b;
          r_fun    <= cmd_fun;
          r_alu_en <= 1'b1;
          r_state  <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // a result arriving in the expiry cycle takes priority over the timeout
          if (alu_out_valid) begin
            r_rsp_data  <= alu_out;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
`ifdef ALU_CMD_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end else if (w_expired) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
`ifdef ALU_CMD_TIMEOUT_EN
            r_rsp_err   <= 1'b1;
`endif
          end
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // gated by RST so no command is advertised while reset is held
  assign cmd_ready = RST && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign A         = r_a;
  assign B         = r_b;
  assign ALU_FUN   = r_fun;
  assign ALU_EN    = r_alu_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl; the bench also plays the ALU using a
// behavioural model. Timeout scenarios run only when ALU_CMD_TIMEOUT_EN is defined.
module tb_alu_cmd_ctrl;
  import alu_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int TMO = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [3:0]    cmd_fun = '0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic [DW-1:0] A, B;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN;
  logic [2*DW-1:0] alu_out = '0;
  logic          alu_out_valid = 1'b0;
  logic          rsp_valid, rsp_err, busy;
  logic          rsp_ready = 1'b0;
  logic [2*DW-1:0] rsp_data;

  int tests = 0, fails = 0, cyc = 0;

  alu_cmd_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .alu_out(alu_out),
    .alu_out_valid(alu_out_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Reference ALU: what a real ALU would return for (fun, a, b)
  function automatic logic [2*DW-1:0] alu_model(input logic [3:0] f,
                                                input logic [DW-1:0] a, b);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    case (f[3:2])
      ARITH: case (f[1:0])
               2'd0: return wa + wb;
               2'd1: return wa - wb;
               2'd2: return wa * wb;
               default: return (b == 0) ? '0 : wa / wb;
             endcase
      LOGIC: case (f[1:0])
               2'd0: return wa & wb;
               2'd1: return wa | wb;
               2'd2: return wa ^ wb;
               default: return ~(wa & wb);
             endcase
      CMP:   case (f[1:0])
               2'd0: return (a == b) ? 1 : 0;
               2'd1: return (a > b)  ? 2 : 0;
               2'd2: return (a < b)  ? 3 : 0;
               default: return '0;
             endcase
      default: case (f[1:0])
               2'd0: return wa << 1;
               2'd1: return wa >> 1;
               2'd2: return wb << 1;
               default: return wb >> 1;
             endcase
    endcase
  endfunction

  // One full command; dly = empty WAIT cycles before the ALU answers, bp = RESP stall cycles
  task automatic run_cmd(input logic [3:0] f, input logic [DW-1:0] a, b,
                         input int dly, input int bp);
    logic [2*DW-1:0] exp;
    exp = alu_model(f, a, b);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_fun = f; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 0; cmd_a = ~a; cmd_b = ~b; cmd_fun = ~f;
    chk("issue_alu_en", ALU_EN, 1);
    chk("issue_A", A, a);
    chk("issue_B", B, b);
    chk("issue_fun", ALU_FUN, f);
    chk("issue_cmd_ready", cmd_ready, 0);
    chk("issue_busy", busy, 1);
    step();
    chk("wait_alu_en", ALU_EN, 0);
    for (int i = 0; i < dly; i++) begin
      step();
      chk("wait_no_rsp", rsp_valid, 0);
      chk("wait_A_hold", A, a);
      chk("wait_alu_en_low", ALU_EN, 0);
    end
    alu_out_valid = 1; alu_out = exp;
    step();
    alu_out_valid = 0; alu_out = ~exp;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, exp);
    chk("resp_err", rsp_err, 0);
    for (int i = 0; i < bp; i++) begin
      alu_out_valid = (i == 0);
      step();
      alu_out_valid = 0;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, exp);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("done_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    int t0, t1;
    // 1: reset with cmd_valid held
    RST = 0; cmd_valid = 1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_fun = 4'hF;
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {A, B, ALU_FUN, ALU_EN, rsp_valid, rsp_err}, 0);
    chk("rst_data", rsp_data, 0);
    RST = 1; #1;
    chk("rel_cmd_ready", cmd_ready, 1);
    cmd_valid = 0;
    step();
    chk("rel_idle", busy, 0);

    // 2: basic op
    run_cmd(4'b0000, 8'h12, 8'h34, 0, 0);

    // 3: backpressure (also stray valid in RESP)
    run_cmd(4'b0110, 8'hF0, 8'h3C, 2, 5);

    // 4: stray valid in IDLE, then back-to-back throughput
    alu_out_valid = 1; alu_out = 16'hDEAD;
    step();
    alu_out_valid = 0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_rsp", rsp_valid, 0);
    t0 = cyc;
    run_cmd(4'b1000, 8'h07, 8'h07, 0, 0);
    t1 = cyc;
    run_cmd(4'b1101, 8'h80, 8'h01, 0, 0);
    chk("throughput_a", t1 - t0, 4);
    chk("throughput_b", cyc - t1, 4);

    // random commands
    for (int n = 0; n < 24; n++) begin
`ifdef ALU_CMD_TIMEOUT_EN
      run_cmd(4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, TMO - 1),
              $urandom_range(0, 3));
`else
      run_cmd(4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20),
              $urandom_range(0, 3));
`endif
    end

`ifdef ALU_CMD_TIMEOUT_EN
    // 5: timeout, then valid landing in the last allowed WAIT cycle
    cmd_valid = 1; cmd_fun = 4'h2; cmd_a = 8'h10; cmd_b = 8'h20;
    step();
    cmd_valid = 0;
    step();
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      chk("tmo_wait", rsp_valid, 0);
    end
    step();
    chk("tmo_valid", rsp_valid, 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("tmo_done", busy, 0);
    run_cmd(4'h2, 8'h10, 8'h20, TMO - 1, 0);
`else
    // without the timer, WAIT must hold indefinitely
    run_cmd(4'h3, 8'hC8, 8'h0A, 40, 1);
`endif

    // 6: reset mid-WAIT, late ALU valid ignored
    cmd_valid = 1; cmd_fun = 4'h4; cmd_a = 8'h33; cmd_b = 8'h44;
    step();
    cmd_valid = 0;
    step(); step(); step();
    chk("midwait_busy", busy, 1);
    RST = 0; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_A", A, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    step();
    RST = 1;
    alu_out_valid = 1; alu_out = 16'hBEEF;
    step();
    alu_out_valid = 0;
    chk("late_valid_rsp", rsp_valid, 0);
    chk("late_valid_busy", busy, 0);
    chk("late_valid_data", rsp_data, 0);
    run_cmd(4'h9, 8'h05, 8'h09, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
